// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: default sizing constants and opcode-field helper shared by the fetch queue files.
package fetch_queue_pkg;
   localparam int ADDR_W_DEF = 12;
   localparam int DATA_W_DEF = 8;
   localparam int OP_W_DEF   = 4;
   localparam int DEPTH_DEF  = 4;
   // Opcode sits in the top ow bits of a dw-bit byte; caller truncates the result to ow bits.
   function automatic logic [31:0] op_field(input logic [31:0] b, input int dw, input int ow);
      return b >> (dw - ow);
   endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: control, ROM and consumer signals of the fetch queue.
interface fetch_queue_if
   import fetch_queue_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int OP_W   = OP_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
);
   logic                     enCounter;
   logic                     load;
   logic [ADDR_W-1:0]        counter_in;
   logic [ADDR_W-1:0]        rom_addr;
   logic [DATA_W-1:0]        rom_data;
   logic                     fetch;
   logic                     valid;
   logic [OP_W-1:0]          instr;
   logic [DATA_W-OP_W-1:0]   oprnd;
   logic [DATA_W-1:0]        program_byte;
   logic [$clog2(DEPTH):0]   level;
   modport master (
      output enCounter, load, counter_in, rom_data, fetch,
      input  rom_addr, valid, instr, oprnd, program_byte, level
   );
   modport slave (
      input  enCounter, load, counter_in, rom_data, fetch,
      output rom_addr, valid, instr, oprnd, program_byte, level
   );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch byte queue with flush; storage is unreset, pointers and level reset asynchronously.
module fetch_fifo
   import fetch_queue_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [DATA_W-1:0]      din,
   output logic [DATA_W-1:0]      dout,
   output logic [$clog2(DEPTH):0] level
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [LW-1:0] level_q, level_d;
   always_comb begin
      wr_d    = flush ? '0 : wr_q + PW'(push);
      rd_d    = flush ? '0 : rd_q + PW'(pop);
      level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         level_q <= level_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= din;
   end
   assign dout  = mem[rd_q];
   assign level = level_q;
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: program counter driving a combinational ROM, prefetching bytes into a FIFO for the consumer.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int OP_W   = OP_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic         clk,
   input  logic         reset,
   fetch_queue_if.slave bus
);
   localparam int LW = $clog2(DEPTH) + 1;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] dout, head;
   logic [LW-1:0]     level;
   logic              valid, push, pop;
   fetch_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (bus.load),
      .din   (bus.rom_data),
      .dout  (dout),
      .level (level)
   );
   // A full queue still accepts a push when the head is popped on the same edge.
   always_comb begin
      valid = level != '0;
      pop   = bus.fetch & valid & ~bus.load;
      push  = bus.enCounter & ~bus.load & ((level != LW'(DEPTH)) | pop);
      pc_d  = bus.load ? bus.counter_in : pc_q + ADDR_W'(push);
      head  = valid ? dout : '0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_q <= '0;
      else pc_q <= pc_d;
   end
   assign bus.rom_addr     = pc_q;
   assign bus.valid        = valid;
   assign bus.program_byte = head;
   assign bus.instr        = OP_W'(op_field(32'(head), DATA_W, OP_W));
   assign bus.oprnd        = head[DATA_W-OP_W-1:0];
   assign bus.level        = level;
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 12, program-counter and ROM address width.
REQ-002 Parameter DATA_W, default 8, program byte width.
REQ-003 Parameter OP_W, default 4, opcode field width (upper bits of byte); operand width = DATA_W-OP_W.
REQ-004 Parameter DEPTH, default 4, prefetch queue entries, power of two, >=2.
REQ-005 clk  input  1  single clock for the whole block; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enCounter  input  1  permits prefetching; PC advances only on a push.
REQ-008 load  input  1  jump request; loads PC and flushes the queue.
REQ-009 counter_in  input  ADDR_W  jump target address.
REQ-010 rom_addr  output  ADDR_W  address to external combinational ROM; always equals PC.
REQ-011 rom_data  input  DATA_W  ROM byte at rom_addr, same cycle.
REQ-012 fetch  input  1  consumer pops the head entry this cycle.
REQ-013 valid  output  1  queue non-empty; head entry is presented.
REQ-014 instr  output  OP_W  head byte[DATA_W-1:DATA_W-OP_W]; all zeros when valid=0.
REQ-015 oprnd  output  DATA_W-OP_W  head byte low bits; all zeros when valid=0.
REQ-016 program_byte  output  DATA_W  head byte; all zeros when valid=0.
REQ-017 level  output  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-018 push = enCounter & ~load & (level<DEPTH | pop); pop = fetch & valid & ~load.
REQ-019 On push, rom_data is written at the tail and PC increments by 1 on the same edge.
REQ-020 PC wraps from 2^ADDR_W-1 to 0 with no flag and no stall.
REQ-021 Full (level=DEPTH) with pop in the same cycle: push and pop both occur; level unchanged.
REQ-022 Empty (level=0) with enCounter=1: fetch is ignored; the byte pushed that edge appears at the head the next cycle (one-cycle ROM-to-head latency).
REQ-023 fetch with valid=0 has no effect; the level never underflows.
REQ-024 load=1 (regardless of enCounter/fetch): PC <= counter_in, level <= 0, no push, no pop; valid=0 the following cycle.
REQ-025 After load at edge N, the byte at counter_in is pushed at edge N+1 if enCounter=1, and valid=1 after edge N+1.
REQ-026 Head outputs are combinational from queue storage and level only; no combinational path from fetch, load, or enCounter to any output.
REQ-027 Order is strictly FIFO; no entry is duplicated or dropped except by the flush.

Reset
REQ-028 Reset forces PC=0, rom_addr=0, level=0, read/write pointers=0, valid=0, instr=0, oprnd=0, program_byte=0 immediately, independent of clk.
REQ-029 Storage contents need not be reset; they are not observable while valid=0.
REQ-030 Reset asserted mid-operation discards all queued entries; the first push after release reads address 0.

Structure
REQ-031 A shared package holds the default parameter constants and an opcode-field extraction function; no typedef depends on the block.
REQ-032 The queue storage/pointer logic is one sub-module, fetch_fifo (parameters DATA_W, DEPTH; ports push, pop, flush, din, dout, level); PC and control stay in fetch_queue.

Verification
REQ-033 Reset, enCounter=1, fetch=0, ROM[i]=i+0x10 -> level 1,2,3,4 then holds at 4; PC=4; head=0x10, instr=0x1, oprnd=0x0.
REQ-034 Full queue, fetch=1 continuously -> one pop and one push per cycle; program_byte steps 0x10,0x11,0x12...; level stays 4.
REQ-035 load=1 with counter_in=0x123, enCounter=1, fetch=1 -> next cycle valid=0, level=0, PC=0x123; following cycle head=ROM[0x123], PC=0x124.
REQ-036 load to 0xFFF, enCounter=1 for 3 cycles -> entries ROM[0xFFF], ROM[0x000], ROM[0x001]; PC=0x002.
REQ-037 enCounter=0, fetch=1 on empty queue -> valid, instr, oprnd, program_byte remain 0; level remains 0.
REQ-038 Reset pulse mid-stream (level=3, PC=0x045) between clock edges -> outputs 0 immediately; after release, first head=ROM[0x000].
